// File: rtl/elementwise_mult_scheduler_pkg.sv
// Shared types and helpers for the element-wise multiply scheduler.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package elementwise_mult_scheduler_pkg;

    // Scheduler control states: waiting for a vector, stepping chunks, holding a result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Chunk counter width; a single-chunk configuration still needs one bit.
    function automatic int chunk_cnt_width(input int chunks);
        return (chunks > 1) ? $clog2(chunks) : 1;
    endfunction

endpackage

// File: rtl/elementwise_mult_scheduler_bank.sv
// Bank of NUM_INSTANCES unsigned N x N multipliers producing exact 2N-bit products.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the scheduler decides when the products are captured.
module parallel_elementwise_multiplication #(
    parameter int N             = 8,
    parameter int NUM_INSTANCES = 2
) (
    input  logic [N*NUM_INSTANCES-1:0]   a,
    input  logic [N*NUM_INSTANCES-1:0]   b,
    output logic [2*N*NUM_INSTANCES-1:0] product
);

    for (genvar i = 0; i < NUM_INSTANCES; i++) begin : g_lane
        logic [2*N-1:0] a_ext;
        logic [2*N-1:0] b_ext;

        // Zero-extend so the multiply is carried out at full product width.
        assign a_ext = {{N{1'b0}}, a[i*N +: N]};
        assign b_ext = {{N{1'b0}}, b[i*N +: N]};
        assign product[i*2*N +: 2*N] = a_ext * b_ext;
    end

endmodule

// File: rtl/elementwise_mult_scheduler.sv
// Streams a VEC_LEN-element vector multiply through a NUM_INSTANCES-lane bank, one chunk per cycle.
// Latency: accept edge t0, out_valid first high in the cycle after edge t0+CHUNKS; one vector per CHUNKS+2 cycles.
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready, no same-cycle re-accept.
module elementwise_mult_scheduler
    import elementwise_mult_scheduler_pkg::*;
#(
    parameter int N             = 8,
    parameter int NUM_INSTANCES = 2,
    parameter int VEC_LEN       = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N*VEC_LEN-1:0]     in_a,
    input  logic [N*VEC_LEN-1:0]     in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*N*VEC_LEN-1:0]   out_result,
    output logic                     busy
);

    localparam int CHUNKS = VEC_LEN / NUM_INSTANCES;
    localparam int CW     = chunk_cnt_width(CHUNKS);
    localparam int LANE_W = N * NUM_INSTANCES;
    localparam int PROD_W = 2 * N * NUM_INSTANCES;
    localparam logic [CW-1:0] LAST_CHUNK = CW'(CHUNKS - 1);

    // A partial final chunk would leave elements unprocessed, so refuse to build.
    if (NUM_INSTANCES < 1 || VEC_LEN < NUM_INSTANCES || (VEC_LEN % NUM_INSTANCES) != 0) begin : g_bad_cfg
        $fatal(1, "VEC_LEN must be a non-zero multiple of NUM_INSTANCES");
    end

    state_t               state;
    state_t               state_nxt;
    logic [CW-1:0]        chunk;
    logic [N*VEC_LEN-1:0] a_reg;
    logic [N*VEC_LEN-1:0] b_reg;
    logic [LANE_W-1:0]    bank_a;
    logic [LANE_W-1:0]    bank_b;
    logic [PROD_W-1:0]    bank_p;
    logic [CHUNKS-1:0]    slice_we;
    logic                 accept;
    logic                 last_chunk;

    assign in_ready   = (state == IDLE);
    assign busy       = (state != IDLE);
    assign out_valid  = (state == DONE);
    assign accept     = in_valid && in_ready;
    assign last_chunk = (chunk == LAST_CHUNK);

    // State register; reset discards any vector in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: accept in IDLE, step chunks in RUN, hold until consumed in DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid)   state_nxt = RUN;
            RUN:  if (last_chunk) state_nxt = DONE;
            DONE: if (out_ready)  state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    // Operand capture on accept and chunk stepping while running.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chunk <= '0;
            a_reg <= '0;
            b_reg <= '0;
        end else if (accept) begin
            chunk <= '0;
            a_reg <= in_a;
            b_reg <= in_b;
        end else if (state == RUN && !last_chunk) begin
            chunk <= chunk + CW'(1);
        end
    end

    // Select the current chunk's operand slices for the bank.
    always_comb begin
        bank_a = a_reg[int'(chunk)*LANE_W +: LANE_W];
        bank_b = b_reg[int'(chunk)*LANE_W +: LANE_W];
    end

    // One write enable per result slice, active for the chunk being processed.
    always_comb begin
        slice_we = '0;
        for (int k = 0; k < CHUNKS; k++) begin
            slice_we[k] = (state == RUN) && (chunk == CW'(k));
        end
    end

    parallel_elementwise_multiplication #(
        .N             (N),
        .NUM_INSTANCES (NUM_INSTANCES)
    ) u_bank (
        .a       (bank_a),
        .b       (bank_b),
        .product (bank_p)
    );

    // Result buffer: cleared on accept, filled slice by slice, frozen in DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_result <= '0;
        end else if (accept) begin
            out_result <= '0;
        end else begin
            for (int k = 0; k < CHUNKS; k++) begin
                if (slice_we[k]) begin
                    out_result[k*PROD_W +: PROD_W] <= bank_p;
                end
            end
        end
    end

endmodule
